// File: rtl/input_vector_buffer.sv
// ---------------------------------------------------------------------------
// input_vector_buffer
//   NUM_CH operand memories that share one write port and one streaming
//   reader. The host loads vectors, then requests rd_len element tuples
//   starting at rd_base; addresses wrap modulo DEPTH. Tuples leave on a
//   valid/ready interface with index, last marker and a done pulse.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   wr_en/wr_addr         write request / element address
//   wr_ch_mask            per-channel write enable (bit c -> channel c)
//   wr_data               channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   wr_reject             write dropped because a stream was active
//   start/rd_base/rd_len  stream request (len 0..DEPTH, larger clamps)
//   busy                  stream in progress
//   out_valid/out_ready   tuple handshake
//   out_data/out_idx      tuple (same packing as wr_data) / ordinal
//   out_last              final tuple of the stream
//   done                  one-cycle pulse at stream end
//   stall_count           (IVB_STALL_CNT_EN only) valid&&!ready cycles
//
// Optional feature macro: IVB_STALL_CNT_EN
// ---------------------------------------------------------------------------

// One channel: synchronous-write memory plus a registered read port that
// only loads while rd_en is high, so the output holds outside a stream.
module ivb_mem_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

module input_vector_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [NUM_CH-1:0]            wr_ch_mask,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic                         wr_reject,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        rd_base,
    input  logic [ADDR_WIDTH:0]          rd_len,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]          out_idx,
    output logic                         out_last,
    output logic                         done
`ifdef IVB_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  wr_reject_q, wr_reject_d;
    logic                  start_acc;
    logic                  last;
    logic [ADDR_WIDTH:0]   len_clamp;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic                  wr_accept;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] wr_data_ch;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] rd_data_ch;

    assign len_clamp = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;
    assign busy      = (state_q == S_STREAM);
    assign last      = valid_q && (idx_q == len_q - LEN_ONE);
    assign wr_accept = wr_en && !busy;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (len_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d  = rd_base;
                        len_d   = len_clamp;
                        idx_d   = '0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                // First STREAM cycle issues the read of idx 0; valid follows.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    if (last) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + LEN_ONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read the tuple that will be on the output next cycle. On a stall this
    // re-reads the current address; memory cannot change while busy, so the
    // output stays stable and no skid buffer is needed.
    assign rd_en   = (state_q == S_STREAM);
    assign rd_addr = base_q + idx_d[ADDR_WIDTH-1:0];

    assign wr_reject_d = wr_en && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign wr_data_ch = wr_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        ivb_mem_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_accept && wr_ch_mask[c]),
            .wr_addr(wr_addr),
            .wr_data(wr_data_ch[c]),
            .rd_en  (rd_en),
            .rd_addr(rd_addr),
            .rd_data(rd_data_ch[c])
        );
    end

    assign out_data  = rd_data_ch;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last;
    assign done      = done_q;
    assign wr_reject = wr_reject_q;

`ifdef IVB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc)
            stall_cnt_d = '0;
        else if (valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    // start_acc only feeds the stall counter.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif
endmodule
